// File: rtl/sa_seq_ctrl.sv
// Pass sequencer for an N x N systolic array: clears the accumulators, streams K operand
// vectors with per-lane skewed valids, waits out the wavefront, then holds done until accepted.
module sa_seq_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  output logic           rd_en,
  output logic [K_W-1:0] rd_addr,
  output logic [N-1:0]   feed_vld,
  output logic           acc_clr,
  output logic           busy,
  output logic           done,
  input  logic           res_rdy
);

  // Drain counter must reach 2N-1.
  localparam int D_W = $clog2(2 * N) + 1;
  localparam logic [D_W-1:0] DRAIN_LAST = D_W'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [K_W-1:0] r_kq;
  logic [K_W-1:0] r_rd_addr;
  logic [D_W-1:0] r_drain_cnt;
  logic           r_rd_en;
  logic           r_acc_clr;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_feed_vld;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; registers not assigned in a branch simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_kq        <= '0;
      r_rd_addr   <= '0;
      r_drain_cnt <= '0;
      r_rd_en     <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_kq      <= k_len;
            r_state   <= S_CLEAR;
            r_acc_clr <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_acc_clr <= 1'b0;
          if (r_kq != '0) begin
            r_state   <= S_FEED;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_FEED: begin
          if (r_rd_addr == r_kq - K_W'(1)) begin
            r_state     <= S_DRAIN;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_drain_cnt <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + K_W'(1);
          end
        end
        S_DRAIN: begin
          // Covers buffer latency, lane skew, PE hops and the result register.
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + D_W'(1);
          end
        end
        S_DONE: begin
          if (res_rdy) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Skew line: lane 0 is the buffer data-valid, each further lane one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feed_vld <= '0;
    end else begin
      r_feed_vld[0] <= r_rd_en;
      for (int i = 1; i < N; i++) begin
        r_feed_vld[i] <= r_feed_vld[i-1];
      end
    end
  end

  assign rd_en    = r_rd_en;
  assign rd_addr  = r_rd_addr;
  assign feed_vld = r_feed_vld;
  assign acc_clr  = r_acc_clr;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl: a cycle-arithmetic model of one pass is compared against every
// output each cycle, and per-phase event statistics are pinned to hand-computed constants.
module tb_sa_seq_ctrl;
  localparam int N   = 4;
  localparam int K_W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           res_rdy = 1'b0;
  logic [K_W-1:0] k_len = '0;
  logic           rd_en;
  logic [K_W-1:0] rd_addr;
  logic [N-1:0]   feed_vld;
  logic           acc_clr;
  logic           busy;
  logic           done;

  sa_seq_ctrl #(.N(N), .K_W(K_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .feed_vld (feed_vld),
    .acc_clr  (acc_clr),
    .busy     (busy),
    .done     (done),
    .res_rdy  (res_rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Phase statistics, restarted whenever the stimulus bumps seg.
  int seg = 0;
  int last_seg = -1;
  int n_clr, n_rd, n_done, n_busy, n_feed;
  int clr1, clr2, done1, f0_first, f3_first, f3_last;
  int addr_log[8];

  // Model of a pass: CLEAR at cycle s, reads s+1..s+kq, done from dstart until accepted.
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_s = 0;
  int          m_kq = 0;
  int          m_dstart = 0;
  logic [N-1:0] m_prev = '0;

  initial begin
    bit e_busy, e_clr, e_rd, e_done;
    int e_addr;
    logic [N-1:0] e_feed;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 1'b0;
        m_prev   = '0;
        chk_en   = 1'b1;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_s      = cyc;
          m_kq     = int'(k_len);
          m_dstart = (m_kq == 0) ? cyc + 1 : cyc + m_kq + 1 + 2 * N;
        end
      end else if (cyc - 1 >= m_dstart && res_rdy) begin
        m_active = 1'b0;
      end
      e_busy = m_active;
      e_clr  = m_active && cyc == m_s;
      e_rd   = m_active && cyc >= m_s + 1 && cyc <= m_s + m_kq;
      e_addr = e_rd ? cyc - m_s - 1 : 0;
      e_done = m_active && cyc >= m_dstart;
      e_feed = m_prev;
      m_prev = {m_prev[N-2:0], e_rd};
      #1;
      if (chk_en) begin
        check("busy",     64'(busy),     64'(e_busy));
        check("acc_clr",  64'(acc_clr),  64'(e_clr));
        check("rd_en",    64'(rd_en),    64'(e_rd));
        check("rd_addr",  64'(rd_addr),  64'(e_addr));
        check("feed_vld", 64'(feed_vld), 64'(e_feed));
        check("done",     64'(done),     64'(e_done));
      end
      if (seg != last_seg) begin
        last_seg = seg;
        n_clr = 0; n_rd = 0; n_done = 0; n_busy = 0; n_feed = 0;
        clr1 = -1; clr2 = -1; done1 = -1; f0_first = -1; f3_first = -1; f3_last = -1;
        for (int i = 0; i < 8; i++) addr_log[i] = -1;
      end
      if (acc_clr === 1'b1) begin
        if (clr1 < 0) clr1 = cyc;
        else if (clr2 < 0) clr2 = cyc;
        n_clr++;
      end
      if (rd_en === 1'b1) begin
        if (n_rd < 8) addr_log[n_rd] = int'(rd_addr);
        n_rd++;
      end
      if (done === 1'b1) begin
        if (done1 < 0) done1 = cyc;
        n_done++;
      end
      if (busy === 1'b1) n_busy++;
      if (feed_vld != '0) n_feed++;
      if (feed_vld[0] === 1'b1 && f0_first < 0) f0_first = cyc;
      if (feed_vld[N-1] === 1'b1) begin
        if (f3_first < 0) f3_first = cyc;
        f3_last = cyc;
      end
    end
  end

  initial begin
    // Reset held with start asserted.
    rst = 1'b1; start = 1'b1; k_len = 8'd3;
    step(3);
    rst = 1'b0; start = 1'b0; seg++;
    step(4);
    check("idle_busy_cnt", 64'(n_busy), 64'd0);

    // Nominal pass, k_len=3, consumer always ready.
    seg++; k_len = 8'd3; res_rdy = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0; k_len = 8'd9;
    step(16);
    check("nom_clr_cnt",   64'(n_clr),          64'd1);
    check("nom_rd_cnt",    64'(n_rd),           64'd3);
    check("nom_addr2",     64'(addr_log[2]),    64'd2);
    check("nom_f0_first",  64'(f0_first - clr1), 64'd2);
    check("nom_f3_first",  64'(f3_first - clr1), 64'd5);
    check("nom_f3_last",   64'(f3_last - clr1),  64'd7);
    check("nom_done_at",   64'(done1 - clr1),    64'd12);
    check("nom_done_cnt",  64'(n_done),         64'd1);
    check("nom_busy_cnt",  64'(n_busy),         64'd13);

    // Backpressure: consumer stalls until cycle 20, start/k_len toggle meanwhile.
    seg++; res_rdy = 1'b0; k_len = 8'd3; start = 1'b1;
    step(1);
    for (int i = 1; i <= 19; i++) begin
      start = i[0];
      k_len = 8'(i * 7);
      step(1);
    end
    res_rdy = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    check("bp_clr_cnt",  64'(n_clr),       64'd1);
    check("bp_rd_cnt",   64'(n_rd),        64'd3);
    check("bp_done_at",  64'(done1 - clr1), 64'd12);
    check("bp_done_cnt", 64'(n_done),      64'd8);
    check("bp_busy_cnt", 64'(n_busy),      64'd20);

    // Zero-length pass.
    seg++; k_len = 8'd0; res_rdy = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    check("zero_rd_cnt",   64'(n_rd),          64'd0);
    check("zero_feed_cnt", 64'(n_feed),        64'd0);
    check("zero_done_at",  64'(done1 - clr1),  64'd1);
    check("zero_done_cnt", 64'(n_done),        64'd1);

    // Abort mid-feed with reset in cycle 4, then a clean k_len=2 pass.
    seg++; k_len = 8'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; seg++;
    step(10);
    check("abort_done_cnt", 64'(n_done), 64'd0);
    check("abort_feed_cnt", 64'(n_feed), 64'd0);
    check("abort_busy_cnt", 64'(n_busy), 64'd0);
    seg++; k_len = 8'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    step(14);
    check("post_rd_cnt",  64'(n_rd),          64'd2);
    check("post_addr0",   64'(addr_log[0]),   64'd0);
    check("post_addr1",   64'(addr_log[1]),   64'd1);
    check("post_done_at", 64'(done1 - clr1),  64'd11);

    // Back-to-back passes with start held high.
    seg++; k_len = 8'd1; res_rdy = 1'b1; start = 1'b1;
    step(26);
    start = 1'b0;
    step(14);
    check("b2b_period",  64'(clr2 - clr1),  64'd12);
    check("b2b_done_at", 64'(done1 - clr1), 64'd10);
    check("b2b_clr_cnt", 64'(n_clr),        64'd3);
    check("b2b_rd_cnt",  64'(n_rd),         64'd3);
    check("b2b_addr1",   64'(addr_log[1]),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
